// File: rtl/pkt_frame_ctrl.sv
// pkt_frame_ctrl: packet framing controller for the assembled-byte stream.
// Detects one of two header bytes, collects PAYLOAD_BYTES payload bytes and
// writes them to the downstream FIFO either per byte or as one packed word.
// An inter-byte timeout aborts stalled packets; dropped writes are counted.
//
// Handshake semantics: byte_assembled is a one-cycle valid strobe with no
// ready back-channel, so every strobe is consumed in the cycle it arrives.
// fifo_full is the downstream "not ready", sampled only in a strobe cycle
// that would write; a write that meets fifo_full=1 is discarded and counted
// in drop_cnt. wr_fifo is a one-cycle valid for wr_data/pkt_type.
module pkt_frame_ctrl #(
    parameter int                DATA_W        = 8,
    parameter int                PAYLOAD_BYTES = 4,
    parameter logic [DATA_W-1:0] HDR_A         = 'hA5,
    parameter logic [DATA_W-1:0] HDR_B         = 'hC3,
    parameter bit                WORD_MODE     = 1'b0,
    parameter int                TIMEOUT       = 1000
) (
    input  logic                            clk_50,
    input  logic                            reset_n,
    input  logic                            byte_assembled,
    input  logic [DATA_W-1:0]               byte_in,
    input  logic                            fifo_full,
    output logic                            wr_fifo,
    output logic [DATA_W*PAYLOAD_BYTES-1:0] wr_data,
    output logic                            pkt_type,
    output logic                            pkt_done,
    output logic                            timeout_err,
    output logic [7:0]                      drop_cnt,
    output logic                            busy,
    output logic                            state_dbg
);

    localparam int WORD_W = DATA_W * PAYLOAD_BYTES;
    localparam int IDX_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMR_EN = (TIMEOUT > 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [WORD_W-1:0]  payload, payload_nxt;
    logic               type_q, type_nxt;
    logic               wr_fifo_nxt;
    logic [WORD_W-1:0]  wr_data_nxt;
    logic               pkt_done_nxt;
    logic               timeout_nxt;
    logic               drop_nxt;
    logic               hdr_hit;

    assign hdr_hit   = (byte_in == HDR_A) || (byte_in == HDR_B);
    assign busy      = (state == PAYLOAD);
    assign state_dbg = state;
    assign pkt_type  = type_q;

    // Next-state and next-output decode; a strobe always beats the timeout.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        timer_nxt    = timer;
        payload_nxt  = payload;
        type_nxt     = type_q;
        wr_fifo_nxt  = 1'b0;
        wr_data_nxt  = wr_data;
        pkt_done_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        drop_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (byte_assembled && hdr_hit) begin
                    state_nxt   = PAYLOAD;
                    idx_nxt     = '0;
                    timer_nxt   = '0;
                    payload_nxt = '0;
                    // HDR_A takes priority when both headers are equal.
                    type_nxt    = (byte_in != HDR_A);
                end
            end
            PAYLOAD: begin
                if (byte_assembled) begin
                    timer_nxt = '0;
                    idx_nxt   = idx + IDX_W'(1);
                    // Slot 0 is the most-significant byte of the packed word.
                    for (int s = 0; s < PAYLOAD_BYTES; s++) begin
                        if (idx == IDX_W'(s)) begin
                            payload_nxt[(PAYLOAD_BYTES-1-s)*DATA_W +: DATA_W] = byte_in;
                        end
                    end
                    if (!WORD_MODE) begin
                        if (!fifo_full) begin
                            wr_fifo_nxt = 1'b1;
                            wr_data_nxt = WORD_W'(byte_in);
                        end else begin
                            drop_nxt = 1'b1;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state_nxt    = IDLE;
                        idx_nxt      = '0;
                        pkt_done_nxt = 1'b1;
                        if (WORD_MODE) begin
                            if (!fifo_full) begin
                                wr_fifo_nxt = 1'b1;
                                wr_data_nxt = payload_nxt;
                            end else begin
                                drop_nxt = 1'b1;
                            end
                        end
                    end
                end else if (TMR_EN && (timer == TMR_LAST)) begin
                    state_nxt   = IDLE;
                    idx_nxt     = '0;
                    timer_nxt   = '0;
                    payload_nxt = '0;
                    timeout_nxt = 1'b1;
                end else if (TMR_EN) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered output strobes.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            timer       <= '0;
            payload     <= '0;
            type_q      <= 1'b0;
            wr_fifo     <= 1'b0;
            wr_data     <= '0;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            timer       <= timer_nxt;
            payload     <= payload_nxt;
            type_q      <= type_nxt;
            wr_fifo     <= wr_fifo_nxt;
            wr_data     <= wr_data_nxt;
            pkt_done    <= pkt_done_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'd0;
        end else if (drop_nxt && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pkt_frame_ctrl.sv
// Bench for pkt_frame_ctrl: a word-mode and a byte-mode instance share one
// stimulus stream; a negedge monitor pops expected writes from per-instance
// queues, and a directed sequence checks strobes, timeout and drop counts.
module tb_pkt_frame_ctrl;

    localparam int WW = 32;

    logic          clk_50 = 1'b0;
    logic          reset_n;
    logic          byte_assembled;
    logic [7:0]    byte_in;
    logic          fifo_full;

    logic          w_wr_fifo, w_pkt_type, w_pkt_done, w_timeout_err, w_busy, w_state_dbg;
    logic [WW-1:0] w_wr_data;
    logic [7:0]    w_drop_cnt;
    logic          b_wr_fifo, b_pkt_type, b_pkt_done, b_timeout_err, b_busy, b_state_dbg;
    logic [WW-1:0] b_wr_data;
    logic [7:0]    b_drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected write entries: {pkt_done, pkt_type, wr_data}.
    logic [WW+1:0] exp_w_q[$];
    logic [WW+1:0] exp_b_q[$];
    logic [WW+1:0] e_w, e_b;

    int exp_drop_w = 0, exp_drop_b = 0;
    int exp_done   = 0, exp_to     = 0;
    int w_done_cnt = 0, b_done_cnt = 0;
    int w_to_cnt   = 0, b_to_cnt   = 0;

    pkt_frame_ctrl #(.WORD_MODE(1'b1), .TIMEOUT(8)) u_word (
        .clk_50(clk_50), .reset_n(reset_n), .byte_assembled(byte_assembled),
        .byte_in(byte_in), .fifo_full(fifo_full), .wr_fifo(w_wr_fifo),
        .wr_data(w_wr_data), .pkt_type(w_pkt_type), .pkt_done(w_pkt_done),
        .timeout_err(w_timeout_err), .drop_cnt(w_drop_cnt), .busy(w_busy),
        .state_dbg(w_state_dbg)
    );

    pkt_frame_ctrl #(.WORD_MODE(1'b0), .TIMEOUT(8)) u_byte (
        .clk_50(clk_50), .reset_n(reset_n), .byte_assembled(byte_assembled),
        .byte_in(byte_in), .fifo_full(fifo_full), .wr_fifo(b_wr_fifo),
        .wr_data(b_wr_data), .pkt_type(b_pkt_type), .pkt_done(b_pkt_done),
        .timeout_err(b_timeout_err), .drop_cnt(b_drop_cnt), .busy(b_busy),
        .state_dbg(b_state_dbg)
    );

    // Clock: 50 MHz.
    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_50) begin
        if (reset_n) begin
            if (w_wr_fifo) begin
                chk("w_write_expected", 64'(exp_w_q.size() != 0), 1);
                if (exp_w_q.size() != 0) begin
                    e_w = exp_w_q.pop_front();
                    chk("w_wr_data", w_wr_data, e_w[WW-1:0]);
                    chk("w_pkt_type", w_pkt_type, e_w[WW]);
                    chk("w_pkt_done_with_wr", w_pkt_done, e_w[WW+1]);
                end
            end
            if (b_wr_fifo) begin
                chk("b_write_expected", 64'(exp_b_q.size() != 0), 1);
                if (exp_b_q.size() != 0) begin
                    e_b = exp_b_q.pop_front();
                    chk("b_wr_data", b_wr_data, e_b[WW-1:0]);
                    chk("b_pkt_type", b_pkt_type, e_b[WW]);
                    chk("b_pkt_done_with_wr", b_pkt_done, e_b[WW+1]);
                end
            end
            if (w_pkt_done)    w_done_cnt++;
            if (b_pkt_done)    b_done_cnt++;
            if (w_timeout_err) w_to_cnt++;
            if (b_timeout_err) b_to_cnt++;
        end
    end

    // Driver: one strobe cycle, returns 1 time unit after the sampling edge.
    task automatic strobe(input logic [7:0] b, input logic full);
        byte_assembled = 1'b1;
        byte_in        = b;
        fifo_full      = full;
        @(posedge clk_50);
        #1;
        byte_assembled = 1'b0;
        fifo_full      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_wr_fifo"},  w_wr_fifo, 0);
        chk({tag, "_w_wr_data"},  w_wr_data, 0);
        chk({tag, "_w_pkt_type"}, w_pkt_type, 0);
        chk({tag, "_w_pkt_done"}, w_pkt_done, 0);
        chk({tag, "_w_timeout"},  w_timeout_err, 0);
        chk({tag, "_w_drop_cnt"}, w_drop_cnt, 0);
        chk({tag, "_w_busy"},     w_busy, 0);
        chk({tag, "_w_state"},    w_state_dbg, 0);
        chk({tag, "_b_wr_fifo"},  b_wr_fifo, 0);
        chk({tag, "_b_wr_data"},  b_wr_data, 0);
        chk({tag, "_b_pkt_type"}, b_pkt_type, 0);
        chk({tag, "_b_pkt_done"}, b_pkt_done, 0);
        chk({tag, "_b_timeout"},  b_timeout_err, 0);
        chk({tag, "_b_drop_cnt"}, b_drop_cnt, 0);
        chk({tag, "_b_busy"},     b_busy, 0);
        chk({tag, "_b_state"},    b_state_dbg, 0);
    endtask

    // One full packet; full_mask bit i raises fifo_full on payload byte i.
    // gap_at >= 0 inserts gap_len idle cycles before that payload byte.
    task automatic send_pkt(input logic [7:0] hdr, input logic [WW-1:0] pw,
                            input logic [3:0] full_mask, input int gap_at,
                            input int gap_len);
        logic       t;
        logic [7:0] b;
        logic       last, full;
        t = (hdr == 8'hC3);
        strobe(hdr, 1'b0);
        chk("w_busy_after_hdr", w_busy, 1);
        chk("b_busy_after_hdr", b_busy, 1);
        for (int i = 0; i < 4; i++) begin
            b    = pw[31-8*i -: 8];
            last = (i == 3);
            full = full_mask[i];
            if (i == gap_at) begin
                idle(gap_len);
                chk("w_busy_in_gap", w_busy, 1);
                chk("w_no_timeout_in_gap", w_timeout_err, 0);
                chk("b_no_timeout_in_gap", b_timeout_err, 0);
            end
            if (!full) exp_b_q.push_back({last, t, 24'h0, b});
            else       exp_drop_b = sat_inc(exp_drop_b);
            if (last) begin
                if (!full) exp_w_q.push_back({1'b1, t, pw});
                else       exp_drop_w = sat_inc(exp_drop_w);
                exp_done++;
            end
            strobe(b, full);
            chk("b_wr_fifo_per_byte", b_wr_fifo, 64'(!full));
            if (last) begin
                chk("w_wr_fifo_last", w_wr_fifo, 64'(!full));
                chk("w_pkt_done_last", w_pkt_done, 1);
                chk("b_pkt_done_last", b_pkt_done, 1);
                chk("w_busy_after_last", w_busy, 0);
            end else begin
                chk("w_no_wr_mid_pkt", w_wr_fifo, 0);
                chk("w_no_done_mid_pkt", w_pkt_done, 0);
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        byte_assembled = 1'b0;
        byte_in        = 8'h00;
        fifo_full      = 1'b0;
        idle(3);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Word packet immediately followed by a byte-mode-style HDR_B packet.
        send_pkt(8'hA5, 32'h11223344, 4'b0000, -1, 0);
        send_pkt(8'hC3, 32'h01020304, 4'b0000, -1, 0);

        // Noise rejection before a header.
        strobe(8'h00, 1'b0);
        chk("noise00_w_busy", w_busy, 0);
        strobe(8'h5A, 1'b0);
        chk("noise5a_b_busy", b_busy, 0);
        send_pkt(8'hA5, 32'hAABBCCDD, 4'b0000, -1, 0);

        // Header values inside the payload are plain data.
        send_pkt(8'hC3, 32'hA5C3A5C3, 4'b0000, -1, 0);

        // Byte mode loses only the byte seen with fifo_full.
        send_pkt(8'hA5, 32'h10203040, 4'b0010, -1, 0);
        chk("w_drop_mid_byte", w_drop_cnt, exp_drop_w);
        chk("b_drop_mid_byte", b_drop_cnt, exp_drop_b);

        // Back-pressure on the last byte, then saturation.
        send_pkt(8'hA5, 32'hCAFEF00D, 4'b1000, -1, 0);
        chk("w_drop_first", w_drop_cnt, exp_drop_w);
        chk("b_drop_first", b_drop_cnt, exp_drop_b);
        for (int k = 0; k < 299; k++) begin
            send_pkt(($urandom_range(0, 1) != 0) ? 8'hC3 : 8'hA5, $urandom,
                     4'b1000, -1, 0);
        end
        chk("w_drop_saturated", w_drop_cnt, 255);
        chk("b_drop_saturated", b_drop_cnt, 255);

        // Timeout abort after two payload bytes.
        strobe(8'hA5, 1'b0);
        exp_b_q.push_back({2'b00, 24'h0, 8'h11});
        strobe(8'h11, 1'b0);
        exp_b_q.push_back({2'b00, 24'h0, 8'h22});
        strobe(8'h22, 1'b0);
        idle(7);
        chk("to_w_busy_before", w_busy, 1);
        chk("to_w_no_err_before", w_timeout_err, 0);
        idle(1);
        exp_to++;
        chk("to_w_err", w_timeout_err, 1);
        chk("to_b_err", b_timeout_err, 1);
        chk("to_w_busy", w_busy, 0);
        chk("to_b_busy", b_busy, 0);
        chk("to_w_no_wr", w_wr_fifo, 0);
        idle(1);
        chk("to_w_err_one_cycle", w_timeout_err, 0);
        send_pkt(8'hA5, 32'h55667788, 4'b0000, -1, 0);

        // Strobe on the eighth idle cycle beats the timeout.
        send_pkt(8'hA5, 32'h11223344, 4'b0000, 2, 7);

        // Asynchronous reset in the middle of a packet.
        strobe(8'hA5, 1'b0);
        exp_b_q.push_back({2'b00, 24'h0, 8'h11});
        strobe(8'h11, 1'b0);
        @(negedge clk_50);
        #1;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_drop_w = 0;
        exp_drop_b = 0;
        @(posedge clk_50);
        #1;
        reset_n = 1'b1;
        send_pkt(8'hC3, 32'hDEADBEEF, 4'b0000, -1, 0);
        chk("w_drop_after_rst", w_drop_cnt, exp_drop_w);
        chk("b_drop_after_rst", b_drop_cnt, exp_drop_b);

        // Final accounting.
        idle(3);
        chk("w_queue_drained", exp_w_q.size(), 0);
        chk("b_queue_drained", exp_b_q.size(), 0);
        chk("w_done_count", w_done_cnt, exp_done);
        chk("b_done_count", b_done_cnt, exp_done);
        chk("w_timeout_count", w_to_cnt, exp_to);
        chk("b_timeout_count", b_to_cnt, exp_to);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
